// File: rtl/dec2to4_if.sv
// ----------------------------------------------------------------------------
// dec2to4_if
// Bundle of the signals exchanged between the select-generating logic and
// the registered 2-to-4 decoder.
//
// Signals:
//   A, B     select, A is the MSB (s = {A,B})
//   En       active-high decode enable
//   cnt_clr  synchronous clear of all activation counters
//   cnt_sel  index of the activation counter presented on cnt_out
//   Z        registered one-hot decode output
//   chg      one-cycle pulse, Z changed on the last edge
//   cnt_out  selected activation counter value
//
// Modports:
//   master   drives select/enable/counter controls, observes the outputs
//   slave    the decoder side
// ----------------------------------------------------------------------------
interface dec2to4_if #(
    parameter int CNT_W = 8
);
    logic             A;
    logic             B;
    logic             En;
    logic             cnt_clr;
    logic [1:0]       cnt_sel;
    logic [3:0]       Z;
    logic             chg;
    logic [CNT_W-1:0] cnt_out;

    modport master (
        output A, B, En, cnt_clr, cnt_sel,
        input  Z, chg, cnt_out
    );

    modport slave (
        input  A, B, En, cnt_clr, cnt_sel,
        output Z, chg, cnt_out
    );
endinterface

// File: rtl/dec2to4_reg.sv
// ----------------------------------------------------------------------------
// dec2to4_reg
// Registered 2-to-4 line decoder with enable. Z is one-hot for s = {A,B}
// when En=1 and all-zero when En=0, with one cycle of latency. chg pulses
// for one cycle whenever Z takes a new value. Four saturating counters
// record how many enabled decodes hit each line; one is read back through
// cnt_out selected by cnt_sel.
//
// Ports:
//   clk  system clock, all state updates on the rising edge
//   rst  synchronous, active-high reset
//   bus  dec2to4_if.slave (A, B, En, cnt_clr, cnt_sel in; Z, chg, cnt_out out)
//
// Update priority: rst > cnt_clr > normal update.
// ----------------------------------------------------------------------------
module dec2to4_reg #(
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    dec2to4_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       sel;
    logic [3:0]       z_q,   z_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q [0:3];
    logic [CNT_W-1:0] cnt_d [0:3];

    assign sel = {bus.A, bus.B};

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        z_d   = 4'b0000;
        cnt_d = cnt_q;

        if (bus.En) begin
            z_d = 4'b0001 << sel;
        end

        // Compare against the value that will be registered, so the pulse
        // lines up with the Z it describes.
        chg_d = (z_d != z_q);

        if (bus.cnt_clr) begin
            // Clear wins over the increment; this cycle's activation is lost.
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = '0;
            end
        end else if (bus.En && (cnt_q[sel] != CNT_MAX)) begin
            cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so all registers see the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q   <= 4'b0000;
            chg_q <= 1'b0;
            // NOTE: the counter array is a handful of flops, not a RAM, and
            // must read zero after reset, so it is reset like any register.
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            z_q   <= z_d;
            chg_q <= chg_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.Z       = z_q;
    assign bus.chg     = chg_q;
    assign bus.cnt_out = cnt_q[bus.cnt_sel];

endmodule

// File: tb/tb_dec2to4_reg.sv
// ----------------------------------------------------------------------------
// tb_dec2to4_reg
// Self-checking bench for dec2to4_reg. Each applied cycle pushes the
// expected {Z, chg} onto a scoreboard queue; after the edge the entry is
// popped and compared with the DUT outputs. A reference model of the four
// activation counters is read back through cnt_sel/cnt_out.
// ----------------------------------------------------------------------------
module tb_dec2to4_reg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    typedef struct {
        logic [3:0] z;
        logic       chg;
    } exp_t;

    logic clk;
    logic rst;

    dec2to4_if #(.CNT_W(CNT_W)) bus ();

    dec2to4_reg #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t             sb_q [$];
    logic [3:0]       m_z;
    logic [CNT_W-1:0] m_cnt [0:3];
    int               n_vec;
    int               n_err;

    // Reference decode table, written out rather than computed.
    function automatic logic [3:0] ref_dec(input logic [1:0] s);
        case (s)
            2'd0:    ref_dec = 4'b0001;
            2'd1:    ref_dec = 4'b0010;
            2'd2:    ref_dec = 4'b0100;
            default: ref_dec = 4'b1000;
        endcase
    endfunction

    // Drive one cycle of stimulus, update the model, push the expectation,
    // then clock the DUT and compare Z/chg against the popped entry.
    task automatic cycle(input string name, input logic r, input logic a,
                         input logic b, input logic en, input logic clr);
        exp_t       e;
        exp_t       got;
        logic [3:0] nz;
        logic [1:0] s;
        rst         = r;
        bus.A       = a;
        bus.B       = b;
        bus.En      = en;
        bus.cnt_clr = clr;
        s = {a, b};
        if (r) begin
            nz    = 4'b0000;
            e.chg = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] = '0;
        end else begin
            nz    = en ? ref_dec(s) : 4'b0000;
            e.chg = (nz != m_z);
            if (clr) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = '0;
            end else if (en && m_cnt[s] != CNT_MAX) begin
                m_cnt[s] = m_cnt[s] + 8'd1;
            end
        end
        e.z = nz;
        m_z = nz;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty at output time", name);
        end else begin
            got = sb_q.pop_front();
            if (bus.Z !== got.z) begin
                n_err++;
                $display("FAIL %s Z: got %b expected %b", name, bus.Z, got.z);
            end
            if (bus.chg !== got.chg) begin
                n_err++;
                $display("FAIL %s chg: got %b expected %b", name, bus.chg, got.chg);
            end
        end
        if ($countones(bus.Z) > 1) begin
            n_err++;
            $display("FAIL %s onehot: Z=%b is multi-hot", name, bus.Z);
        end
    endtask

    // Read one counter back through the combinational mux.
    task automatic check_cnt(input string name, input int idx);
        bus.cnt_sel = 2'(idx);
        #1;
        n_vec++;
        if (bus.cnt_out !== m_cnt[idx]) begin
            n_err++;
            $display("FAIL %s cnt[%0d]: got %0d expected %0d",
                     name, idx, bus.cnt_out, m_cnt[idx]);
        end
    endtask

    task automatic check_all_cnts(input string name);
        for (int i = 0; i < 4; i++) check_cnt(name, i);
    endtask

    task automatic test_reset();
        cycle("reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("reset2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all_cnts("reset");
    endtask

    task automatic test_disabled_sweep();
        for (int s = 0; s < 4; s++) begin
            cycle("disabled", 1'b0, s[1], s[0], 1'b0, 1'b0);
        end
        check_all_cnts("disabled");
    endtask

    task automatic test_enabled_sweep();
        cycle("en_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            cycle("enabled", 1'b0, s[1], s[0], 1'b1, 1'b0);
        end
        check_all_cnts("enabled");
    endtask

    task automatic test_enable_toggle();
        cycle("tog_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("toggle0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("toggle1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("toggle2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("toggle3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_cnt("toggle", 2);
    endtask

    task automatic test_saturation_clear();
        for (int i = 0; i < 300; i++) begin
            cycle("saturate", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        check_all_cnts("saturate");
        cycle("sat_hold", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_cnt("sat_hold", 3);
        cycle("clear", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_all_cnts("clear");
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 3; i++) begin
            cycle("midrun", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        check_cnt("midrun_pre", 1);
        cycle("midrun_rst", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all_cnts("midrun_rst");
        cycle("midrun_rel", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all_cnts("midrun_rel");
    endtask

    task automatic test_random();
        logic [3:0] r;
        for (int i = 0; i < 1000; i++) begin
            r = 4'($urandom);
            // Keep clears rare so counters get a chance to build up.
            cycle("random", 1'b0, r[0], r[1], r[2],
                  ($urandom_range(0, 31) == 0));
            check_cnt("random", $urandom_range(0, 3));
        end
        check_all_cnts("random_end");
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        m_z         = 4'b0000;
        for (int i = 0; i < 4; i++) m_cnt[i] = '0;
        rst         = 1'b1;
        bus.A       = 1'b0;
        bus.B       = 1'b0;
        bus.En      = 1'b0;
        bus.cnt_clr = 1'b0;
        bus.cnt_sel = 2'd0;
        @(posedge clk);
        #1;

        test_reset();
        test_disabled_sweep();
        test_enabled_sweep();
        test_enable_toggle();
        test_saturation_clear();
        test_reset_midrun();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dec2to4_reg.md
# dec2to4_reg

Registered 2-to-4 line decoder with active-high enable, built for the lab decoder exercise. It decodes the 2-bit select {A,B} into a one-hot 4-bit output Z when enabled and drives all-zero when disabled. It also flags output changes and keeps per-line activation counters for bench and debug readback. It sits between the select-generating logic and downstream one-hot consumers, fully synchronous to one clock.

## Interface
- CNT_W, 8, width of each per-line activation counter (saturating)
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- A  input  1  select MSB
- B  input  1  select LSB
- En  input  1  active-high decode enable
- cnt_clr  input  1  synchronous clear of all activation counters
- cnt_sel  input  2  index of the counter presented on cnt_out
- Z  output  4  registered one-hot decode output, active-high
- chg  output  1  one-cycle pulse: Z changed value on this edge
- cnt_out  output  CNT_W  value of the activation counter selected by cnt_sel (combinational mux of registered counters)

## Operation
- Select index s = {A,B}; A is the MSB, so A=0,B=1 gives s=1 and A=1,B=0 gives s=2.
- Next Z:
  - En=1: bit s is 1 and all other bits are 0. The mapping is 00→0001, 01→0010, 10→0100, 11→1000.
  - En=0: 0000, regardless of A and B.
- chg: on each edge, chg_next = (Z_next != Z_current), registered alongside Z.
- Activation counters cnt[0..3], CNT_W bits each:
  - On each edge with En=1, cnt[s] increments by 1 and saturates at 2^CNT_W−1; it never wraps.
  - With En=0, no counter changes.
  - cnt_clr=1 zeroes all four counters on that edge. It has priority over an increment in the same cycle, and that cycle's activation is not counted.
- cnt_out = cnt[cnt_sel]. It is combinational from registered state and has no extra latency.
- Priority order: rst > cnt_clr > normal update.
- Z is always either one-hot or all-zero; no other codes are legal.
- Inputs are assumed synchronous to clk; the block has no internal synchronizers.

## Timing
- Latency: A/B/En sampled on rising edge k appear on Z at edge k (registered), visible during cycle k+1. Latency is 1 cycle, and a new value is accepted every cycle.
- chg is valid in the same cycle as the Z value it describes and stays high for exactly 1 cycle per change.
- Counter updates land on the same edge as the corresponding Z update.
- Reset (rst=1 on an edge):
  - Z=0000, chg=0, and all counters are 0, so cnt_out=0.
  - Inputs are ignored during reset.
  - The first edge after rst deasserts decodes normally. chg on that edge follows the rule above, so it is 1 if En=1.
- Reset asserted mid-operation clears state on that edge; no activation in that cycle is counted.
- Changing En in a cycle takes effect on the next Z exactly like a select change. En 1→0 forces 0000 and pulses chg if Z was nonzero.

## Test plan
- Disabled sweep: rst, then En=0 with {A,B}=00,01,10,11 for one cycle each → Z=0000 throughout, chg=0, all counters 0.
- Enabled sweep: En=1, {A,B}=00,01,10,11 → Z=0001,0010,0100,1000 one cycle after each input. chg=1 on every step, including the first step from 0000. cnt_sel 0..3 each reads 1.
- Enable toggle: hold {A,B}=10, En 0→1→1→0 → Z=0000,0100,0100,0000 and chg=0,1,0,1. cnt[2] reads 2.
- Saturation and clear: En=1, s=3 held for 300 cycles → cnt[3]=255 (CNT_W=8) and stays 255. Then pulse cnt_clr with En=1 for one cycle → all counters read 0 the next cycle.
- Reset mid-run: with En=1, s=1, and counters nonzero, assert rst for one cycle → next cycle Z=0000, chg=0, counters 0. After release, Z=0010 and chg=1.
- Randomized: 1000 cycles of random A/B/En/cnt_clr → Z matches a reference decoder delayed 1 cycle. Z is never multi-hot. The counters match a reference model.
